decode_stage: RTL and testbench

Registered, back-pressured RV32I instruction decode stage with optional M-extension support. It sits between fetch and execute in the core pipeline:
- accepts one instruction plus PC per valid/ready handshake;
- fully decodes it (register indices, sign-extended immediate, ALU operand sources, ALU op, memory and write-back controls, illegal-instruction flag);
- presents the result one cycle later;
- holds a skid entry so full throughput survives execute-side stalls.

---
 rtl/decode_pkg.sv | 82 ++++++++
 rtl/decode_comb.sv | 153 +++++++++++++++
 rtl/decode_stage.sv | 127 ++++++++++++
 tb/tb_decode_stage.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the RV32I decode stage.
//   - RV32I major opcode constants
//   - AluOp encoding (alu_op_e)
//   - LHS/RHS operand source selectors
//   - decode_ctrl_t: the decoded control bundle. PC and the immediate are
//     XLEN wide and travel beside it, because a package cannot be
//     parameterised.
//   - base_alu(): maps funct3 to the ALU op shared by OP and OP-IMM.
package decode_pkg;

  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP      = 7'b0110011;
  localparam logic [6:0] OPC_MISCMEM = 7'b0001111;

  localparam logic [1:0] LHS_RS1  = 2'd0;
  localparam logic [1:0] LHS_PC   = 2'd1;
  localparam logic [1:0] LHS_ZERO = 2'd2;

  localparam logic [1:0] RHS_RS2  = 2'd0;
  localparam logic [1:0] RHS_IMM  = 2'd1;
  localparam logic [1:0] RHS_FOUR = 2'd2;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_PASSB  = 5'd10,
    ALU_MUL    = 5'd11,
    ALU_MULH   = 5'd12,
    ALU_MULHSU = 5'd13,
    ALU_MULHU  = 5'd14,
    ALU_DIV    = 5'd15,
    ALU_DIVU   = 5'd16,
    ALU_REM    = 5'd17,
    ALU_REMU   = 5'd18
  } alu_op_e;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [1:0] lhs;
    logic [1:0] rhs;
    alu_op_e    aluop;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
    logic       branch;
    logic       jump;
    logic [2:0] memsize;
    logic       invalid;
  } decode_ctrl_t;

  // funct3 -> ALU op for the unmodified (funct7 = 0) OP / OP-IMM forms.
  function automatic alu_op_e base_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  base_alu = ALU_ADD;
      3'b001:  base_alu = ALU_SLL;
      3'b010:  base_alu = ALU_SLT;
      3'b011:  base_alu = ALU_SLTU;
      3'b100:  base_alu = ALU_XOR;
      3'b101:  base_alu = ALU_SRL;
      3'b110:  base_alu = ALU_OR;
      default: base_alu = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_comb.sv
// decode_comb: purely combinational RV32I (+ optional M) decoder.
// Ports:
//   instruction  in   32    raw instruction word
//   ctrl         out  bundle register indices, operand sources, ALU op, strobes
//   imm          out  XLEN  sign-extended immediate (0 for R-type)
module decode_comb
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit SUPPORT_M = 1'b0
) (
  input  logic [31:0]     instruction,
  output decode_ctrl_t    ctrl,
  output logic [XLEN-1:0] imm
);

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm32;
  logic        illegal;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  // The signed cast widens with sign extension for XLEN = 64.
  assign imm = XLEN'($signed(imm32));

  always_comb begin
    ctrl       = '0;
    ctrl.rd    = instruction[11:7];
    ctrl.rs1   = instruction[19:15];
    ctrl.rs2   = instruction[24:20];
    ctrl.aluop = ALU_ADD;
    imm32      = '0;
    illegal    = 1'b0;

    case (opcode)
      OPC_LUI: begin
        imm32         = {instruction[31:12], 12'b0};
        ctrl.lhs      = LHS_ZERO;
        ctrl.rhs      = RHS_IMM;
        ctrl.regwrite = 1'b1;
      end
      OPC_AUIPC: begin
        imm32         = {instruction[31:12], 12'b0};
        ctrl.lhs      = LHS_PC;
        ctrl.rhs      = RHS_IMM;
        ctrl.regwrite = 1'b1;
      end
      OPC_JAL: begin
        imm32 = {{12{instruction[31]}}, instruction[19:12], instruction[20],
                 instruction[30:21], 1'b0};
        ctrl.lhs      = LHS_PC;
        ctrl.rhs      = RHS_FOUR;
        ctrl.jump     = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OPC_JALR: begin
        // The ALU produces the link value; rs1 + imm is formed downstream.
        imm32         = {{20{instruction[31]}}, instruction[31:20]};
        ctrl.lhs      = LHS_PC;
        ctrl.rhs      = RHS_FOUR;
        ctrl.jump     = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OPC_BRANCH: begin
        imm32 = {{20{instruction[31]}}, instruction[7], instruction[30:25],
                 instruction[11:8], 1'b0};
        ctrl.branch = 1'b1;
        case (funct3[2:1])
          2'b00:   ctrl.aluop = ALU_SUB;
          2'b10:   ctrl.aluop = ALU_SLT;
          2'b11:   ctrl.aluop = ALU_SLTU;
          default: illegal    = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        imm32         = {{20{instruction[31]}}, instruction[31:20]};
        ctrl.rhs      = RHS_IMM;
        ctrl.memread  = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.memsize  = funct3;
        if (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111)
          illegal = 1'b1;
      end
      OPC_STORE: begin
        imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
        ctrl.rhs      = RHS_IMM;
        ctrl.memwrite = 1'b1;
        ctrl.memsize  = funct3;
        if (funct3 >= 3'b011)
          illegal = 1'b1;
      end
      OPC_OPIMM: begin
        imm32         = {{20{instruction[31]}}, instruction[31:20]};
        ctrl.rhs      = RHS_IMM;
        ctrl.regwrite = 1'b1;
        ctrl.aluop    = base_alu(funct3);
        // Shift-immediates reuse the upper immediate bits as funct7.
        if (funct3 == 3'b001 && funct7 != 7'b0000000)
          illegal = 1'b1;
        if (funct3 == 3'b101) begin
          if (funct7 == 7'b0100000)
            ctrl.aluop = ALU_SRA;
          else if (funct7 != 7'b0000000)
            illegal = 1'b1;
        end
      end
      OPC_OP: begin
        ctrl.regwrite = 1'b1;
        case (funct7)
          7'b0000000: ctrl.aluop = base_alu(funct3);
          7'b0100000: begin
            if (funct3 == 3'b000)
              ctrl.aluop = ALU_SUB;
            else if (funct3 == 3'b101)
              ctrl.aluop = ALU_SRA;
            else
              illegal = 1'b1;
          end
          7'b0000001: begin
            if (SUPPORT_M)
              ctrl.aluop = alu_op_e'(5'(ALU_MUL) + 5'(funct3));
            else
              illegal = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      OPC_MISCMEM: begin
        // FENCE family: no architectural effect in this core.
      end
      default: illegal = 1'b1;
    endcase

    if (instruction[1:0] != 2'b11)
      illegal = 1'b1;

    ctrl.invalid = illegal;
    if (illegal) begin
      ctrl.regwrite = 1'b0;
      ctrl.memread  = 1'b0;
      ctrl.memwrite = 1'b0;
      ctrl.branch   = 1'b0;
      ctrl.jump     = 1'b0;
    end
    if (ctrl.rd == 5'd0)
      ctrl.regwrite = 1'b0;
  end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: registered, back-pressured decode stage with one skid entry.
// Ports:
//   Clock, Reset_n (sync active-low), Flush (sync)
//   InValid/InReady, Instruction, PCIn          : fetch-side handshake
//   OutValid/OutReady, PCOut, RD/RS1/RS2,
//   DecodedImediate, LHSsource, RHSsource, AluOp,
//   RegWrite/MemRead/MemWrite/Branch/Jump,
//   MemSize, InvalidInstructionSignal            : execute-side bundle
module decode_stage
  import decode_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter bit SUPPORT_M = 1'b0
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic            Flush,
  input  logic            InValid,
  output logic            InReady,
  input  logic [31:0]     Instruction,
  input  logic [XLEN-1:0] PCIn,
  output logic            OutValid,
  input  logic            OutReady,
  output logic [XLEN-1:0] PCOut,
  output logic [4:0]      RD,
  output logic [4:0]      RS1,
  output logic [4:0]      RS2,
  output logic [XLEN-1:0] DecodedImediate,
  output logic [1:0]      LHSsource,
  output logic [1:0]      RHSsource,
  output logic [4:0]      AluOp,
  output logic            RegWrite,
  output logic            MemRead,
  output logic            MemWrite,
  output logic            Branch,
  output logic            Jump,
  output logic [2:0]      MemSize,
  output logic            InvalidInstructionSignal
);

  decode_ctrl_t    dec_ctrl;
  logic [XLEN-1:0] dec_imm;

  decode_ctrl_t    out_ctrl;
  logic [XLEN-1:0] out_imm;
  logic [XLEN-1:0] out_pc;
  logic            out_valid;

  decode_ctrl_t    skid_ctrl;
  logic [XLEN-1:0] skid_imm;
  logic [XLEN-1:0] skid_pc;
  logic            skid_valid;

  logic accept;
  logic out_free;

  decode_comb #(
    .XLEN      (XLEN),
    .SUPPORT_M (SUPPORT_M)
  ) u_decode_comb (
    .instruction (Instruction),
    .ctrl        (dec_ctrl),
    .imm         (dec_imm)
  );

  // InReady comes straight from a flop so fetch never sees a combinational
  // path back from OutReady.
  assign InReady  = !skid_valid;
  assign accept   = InValid && InReady;
  assign out_free = !out_valid || OutReady;

  // A free output slot drains the skid before taking new input; since a
  // full skid also holds InReady low, the skid is always the older entry.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      out_valid  <= 1'b0;
      out_ctrl   <= '0;
      out_imm    <= '0;
      out_pc     <= '0;
      skid_valid <= 1'b0;
      skid_ctrl  <= '0;
      skid_imm   <= '0;
      skid_pc    <= '0;
    end else if (Flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_free) begin
      if (skid_valid) begin
        out_valid  <= 1'b1;
        out_ctrl   <= skid_ctrl;
        out_imm    <= skid_imm;
        out_pc     <= skid_pc;
        skid_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_ctrl  <= dec_ctrl;
        out_imm   <= dec_imm;
        out_pc    <= PCIn;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid <= 1'b1;
      skid_ctrl  <= dec_ctrl;
      skid_imm   <= dec_imm;
      skid_pc    <= PCIn;
    end
  end

  assign OutValid                 = out_valid;
  assign PCOut                    = out_pc;
  assign RD                       = out_ctrl.rd;
  assign RS1                      = out_ctrl.rs1;
  assign RS2                      = out_ctrl.rs2;
  assign DecodedImediate          = out_imm;
  assign LHSsource                = out_ctrl.lhs;
  assign RHSsource                = out_ctrl.rhs;
  assign AluOp                    = out_ctrl.aluop;
  assign RegWrite                 = out_ctrl.regwrite;
  assign MemRead                  = out_ctrl.memread;
  assign MemWrite                 = out_ctrl.memwrite;
  assign Branch                   = out_ctrl.branch;
  assign Jump                     = out_ctrl.jump;
  assign MemSize                  = out_ctrl.memsize;
  assign InvalidInstructionSignal = out_ctrl.invalid;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed bench for decode_stage. A 32-bit, SUPPORT_M = 0
// instance is scoreboarded field by field; a 64-bit, SUPPORT_M = 1 instance
// shares the same inputs and is spot-checked for M decode and 64-bit
// sign extension.
module tb_decode_stage;

  localparam logic [4:0] A_ADD = 5'd0;
  localparam logic [4:0] A_SUB = 5'd1;
  localparam logic [4:0] A_MUL = 5'd11;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [1:0]  lhs;
    logic [1:0]  rhs;
    logic [4:0]  alu;
    logic [4:0]  strobes;
    logic [2:0]  msz;
    logic        inv;
    logic        full;
    logic        rs1c;
    logic        rs2c;
  } exp_t;

  logic        Clock = 1'b0;
  logic        Reset_n, Flush, InValid, OutReady;
  logic [31:0] Instruction, PCIn;

  logic        InReady, OutValid, RegWrite, MemRead, MemWrite, Branch, Jump, Invalid;
  logic [31:0] PCOut, Imm;
  logic [4:0]  RD, RS1, RS2, AluOp;
  logic [1:0]  LHS, RHS;
  logic [2:0]  MemSize;

  logic        mInReady, mOutValid, mRegWrite, mMemRead, mMemWrite, mBranch, mJump, mInvalid;
  logic [63:0] mPCOut, mImm;
  logic [4:0]  mRD, mRS1, mRS2, mAluOp;
  logic [1:0]  mLHS, mRHS;
  logic [2:0]  mMemSize;

  exp_t expQ[$];
  int   totalCount = 0;
  int   passCount  = 0;

  always #5 Clock = ~Clock;

  decode_stage #(.XLEN(32), .SUPPORT_M(1'b0)) dut (
    .Clock(Clock), .Reset_n(Reset_n), .Flush(Flush), .InValid(InValid),
    .InReady(InReady), .Instruction(Instruction), .PCIn(PCIn),
    .OutValid(OutValid), .OutReady(OutReady), .PCOut(PCOut), .RD(RD),
    .RS1(RS1), .RS2(RS2), .DecodedImediate(Imm), .LHSsource(LHS),
    .RHSsource(RHS), .AluOp(AluOp), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .Branch(Branch), .Jump(Jump), .MemSize(MemSize),
    .InvalidInstructionSignal(Invalid)
  );

  decode_stage #(.XLEN(64), .SUPPORT_M(1'b1)) dutM (
    .Clock(Clock), .Reset_n(Reset_n), .Flush(Flush), .InValid(InValid),
    .InReady(mInReady), .Instruction(Instruction), .PCIn({32'b0, PCIn}),
    .OutValid(mOutValid), .OutReady(OutReady), .PCOut(mPCOut), .RD(mRD),
    .RS1(mRS1), .RS2(mRS2), .DecodedImediate(mImm), .LHSsource(mLHS),
    .RHSsource(mRHS), .AluOp(mAluOp), .RegWrite(mRegWrite), .MemRead(mMemRead),
    .MemWrite(mMemWrite), .Branch(mBranch), .Jump(mJump), .MemSize(mMemSize),
    .InvalidInstructionSignal(mInvalid)
  );

  // Single comparison point: every check in the bench funnels through here.
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    totalCount++;
    assert (obs === exp) begin
      passCount++;
    end else begin
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [31:0] instr, input logic [31:0] pc);
    InValid     = valid;
    Instruction = instr;
    PCIn        = pc;
  endtask

  function automatic exp_t mk(input logic [31:0] pc, input logic [4:0] rd,
                              input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [31:0] imm, input logic [1:0] lhs,
                              input logic [1:0] rhs, input logic [4:0] alu,
                              input logic [4:0] strobes, input logic [2:0] msz,
                              input logic inv, input logic full,
                              input logic rs1c, input logic rs2c);
    exp_t e;
    e.pc = pc; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
    e.lhs = lhs; e.rhs = rhs; e.alu = alu; e.strobes = strobes; e.msz = msz;
    e.inv = inv; e.full = full; e.rs1c = rs1c; e.rs2c = rs2c;
    return e;
  endfunction

  // Pops the oldest expected bundle and compares it with the main DUT.
  // strobes = {RegWrite, MemRead, MemWrite, Branch, Jump}
  task automatic checkOutput();
    exp_t e;
    chk("outvalid", 64'(OutValid), 64'd1);
    chk("scoreboard_nonempty", 64'(expQ.size() != 0), 64'd1);
    if (expQ.size() == 0) return;
    e = expQ.pop_front();
    chk($sformatf("pc@%0h", e.pc), 64'(PCOut), 64'(e.pc));
    chk($sformatf("rd@%0h", e.pc), 64'(RD), 64'(e.rd));
    if (e.rs1c) chk($sformatf("rs1@%0h", e.pc), 64'(RS1), 64'(e.rs1));
    if (e.rs2c) chk($sformatf("rs2@%0h", e.pc), 64'(RS2), 64'(e.rs2));
    chk($sformatf("strobes@%0h", e.pc),
        64'({RegWrite, MemRead, MemWrite, Branch, Jump}), 64'(e.strobes));
    chk($sformatf("invalid@%0h", e.pc), 64'(Invalid), 64'(e.inv));
    if (e.full) begin
      chk($sformatf("imm@%0h", e.pc), 64'(Imm), 64'(e.imm));
      chk($sformatf("lhs@%0h", e.pc), 64'(LHS), 64'(e.lhs));
      chk($sformatf("rhs@%0h", e.pc), 64'(RHS), 64'(e.rhs));
      chk($sformatf("aluop@%0h", e.pc), 64'(AluOp), 64'(e.alu));
      if (e.strobes[3] || e.strobes[2])
        chk($sformatf("memsize@%0h", e.pc), 64'(MemSize), 64'(e.msz));
    end
  endtask

  logic [31:0] progInstr[12];
  exp_t        progExp[12];

  initial begin
    // Directed program: pc, rd, rs1, rs2, imm, lhs, rhs, alu, strobes, msz, inv, full, rs1c, rs2c
    progInstr[0]  = 32'h002081B3; progExp[0]  = mk(32'h100, 3, 1, 2, 32'h0, 0, 0, A_ADD, 5'b10000, 0, 0, 1, 1, 1);
    progInstr[1]  = 32'hFFF00093; progExp[1]  = mk(32'h104, 1, 0, 0, 32'hFFFFFFFF, 0, 1, A_ADD, 5'b10000, 0, 0, 1, 1, 0);
    progInstr[2]  = 32'hFE000EE3; progExp[2]  = mk(32'h108, 29, 0, 0, 32'hFFFFFFFC, 0, 0, A_SUB, 5'b00010, 0, 0, 1, 1, 1);
    progInstr[3]  = 32'h022081B3; progExp[3]  = mk(32'h10C, 3, 1, 2, 32'h0, 0, 0, A_ADD, 5'b00000, 0, 1, 0, 1, 1);
    progInstr[4]  = 32'h00000000; progExp[4]  = mk(32'h110, 0, 0, 0, 32'h0, 0, 0, A_ADD, 5'b00000, 0, 1, 0, 1, 1);
    progInstr[5]  = 32'hFFFFFFFF; progExp[5]  = mk(32'h114, 31, 31, 31, 32'h0, 0, 0, A_ADD, 5'b00000, 0, 1, 0, 1, 1);
    progInstr[6]  = 32'h00208033; progExp[6]  = mk(32'h118, 0, 1, 2, 32'h0, 0, 0, A_ADD, 5'b00000, 0, 0, 1, 1, 1);
    progInstr[7]  = 32'h00812503; progExp[7]  = mk(32'h11C, 10, 2, 0, 32'h8, 0, 1, A_ADD, 5'b11000, 3'd2, 0, 1, 1, 0);
    progInstr[8]  = 32'h00512623; progExp[8]  = mk(32'h120, 12, 2, 5, 32'hC, 0, 1, A_ADD, 5'b00100, 3'd2, 0, 1, 1, 1);
    progInstr[9]  = 32'h008000EF; progExp[9]  = mk(32'h124, 1, 0, 0, 32'h8, 1, 2, A_ADD, 5'b10001, 0, 0, 1, 0, 0);
    progInstr[10] = 32'h12345237; progExp[10] = mk(32'h128, 4, 0, 0, 32'h12345000, 2, 1, A_ADD, 5'b10000, 0, 0, 1, 0, 0);
    progInstr[11] = 32'h422081B3; progExp[11] = mk(32'h12C, 3, 1, 2, 32'h0, 0, 0, A_ADD, 5'b00000, 0, 1, 0, 1, 1);

    Reset_n = 1'b0; Flush = 1'b0; OutReady = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0);
    step(); step();
    chk("reset_outvalid", 64'(OutValid), 64'd0);
    chk("reset_inready", 64'(InReady), 64'd1);
    chk("reset_rd", 64'(RD), 64'd0);
    Reset_n = 1'b1;
    step();

    // Full-throughput stream, one result per cycle.
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, progInstr[i], progExp[i].pc);
      expQ.push_back(progExp[i]);
      if (i > 0) checkOutput();
      step();
    end
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput();
    step();
    chk("drain_outvalid", 64'(OutValid), 64'd0);

    // M decode on the SUPPORT_M instance, 64-bit sign extension.
    applyStimulus(1'b1, 32'h022081B3, 32'h200);
    expQ.push_back(mk(32'h200, 3, 1, 2, 32'h0, 0, 0, A_ADD, 5'b00000, 0, 1, 0, 1, 1));
    step();
    applyStimulus(1'b1, 32'hFFF00093, 32'h204);
    expQ.push_back(mk(32'h204, 1, 0, 0, 32'hFFFFFFFF, 0, 1, A_ADD, 5'b10000, 0, 0, 1, 1, 0));
    checkOutput();
    chk("m_aluop_mul", 64'(mAluOp), 64'(A_MUL));
    chk("m_invalid_mul", 64'(mInvalid), 64'd0);
    chk("m_regwrite_mul", 64'(mRegWrite), 64'd1);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput();
    chk("m_imm64", mImm, 64'hFFFF_FFFF_FFFF_FFFF);
    step();

    // Back-pressure: three back-to-back instructions with OutReady low.
    OutReady = 1'b0;
    applyStimulus(1'b1, 32'h00500293, 32'h300);
    expQ.push_back(mk(32'h300, 5, 0, 0, 32'h5, 0, 1, A_ADD, 5'b10000, 0, 0, 1, 1, 0));
    step();
    chk("stall_inready_1", 64'(InReady), 64'd1);
    applyStimulus(1'b1, 32'h00600313, 32'h304);
    expQ.push_back(mk(32'h304, 6, 0, 0, 32'h6, 0, 1, A_ADD, 5'b10000, 0, 0, 1, 1, 0));
    step();
    chk("stall_inready_2", 64'(InReady), 64'd0);
    applyStimulus(1'b1, 32'h00700393, 32'h308);
    step();
    chk("stall_inready_3", 64'(InReady), 64'd0);
    chk("stall_hold_rd", 64'(RD), 64'd5);
    OutReady = 1'b1;
    checkOutput();
    step();
    chk("skid_drain_inready", 64'(InReady), 64'd1);
    expQ.push_back(mk(32'h308, 7, 0, 0, 32'h7, 0, 1, A_ADD, 5'b10000, 0, 0, 1, 1, 0));
    checkOutput();
    step();
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput();
    step();
    chk("stall_drain_outvalid", 64'(OutValid), 64'd0);

    // Flush with a full skid and an input presented in the flush cycle.
    OutReady = 1'b0;
    applyStimulus(1'b1, 32'h00500293, 32'h400);
    step();
    applyStimulus(1'b1, 32'h00600313, 32'h404);
    step();
    chk("flush_pre_inready", 64'(InReady), 64'd0);
    Flush = 1'b1;
    applyStimulus(1'b1, 32'h00700393, 32'h408);
    step();
    Flush = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    expQ.delete();
    chk("flush_outvalid", 64'(OutValid), 64'd0);
    chk("flush_inready", 64'(InReady), 64'd1);
    OutReady = 1'b1;
    step();
    chk("flush_no_ghost", 64'(OutValid), 64'd0);
    applyStimulus(1'b1, 32'h002081B3, 32'h410);
    expQ.push_back(mk(32'h410, 3, 1, 2, 32'h0, 0, 0, A_ADD, 5'b10000, 0, 0, 1, 1, 1));
    step();
    applyStimulus(1'b0, 32'h0, 32'h0);
    checkOutput();
    step();

    // Same scenario, cleared by reset instead of flush.
    OutReady = 1'b0;
    applyStimulus(1'b1, 32'h00500293, 32'h500);
    step();
    applyStimulus(1'b1, 32'h00600313, 32'h504);
    step();
    Reset_n = 1'b0;
    applyStimulus(1'b1, 32'h00700393, 32'h508);
    step();
    Reset_n = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0);
    chk("rst_outvalid", 64'(OutValid), 64'd0);
    chk("rst_inready", 64'(InReady), 64'd1);
    chk("rst_pc", 64'(PCOut), 64'd0);
    chk("rst_regidx", 64'({RD, RS1, RS2}), 64'd0);
    chk("rst_imm", 64'(Imm), 64'd0);
    chk("rst_src", 64'({LHS, RHS}), 64'd0);
    chk("rst_aluop", 64'(AluOp), 64'd0);
    chk("rst_strobes", 64'({RegWrite, MemRead, MemWrite, Branch, Jump}), 64'd0);
    chk("rst_memsize_inv", 64'({MemSize, Invalid}), 64'd0);
    OutReady = 1'b1;
    step();
    chk("rst_no_ghost", 64'(OutValid), 64'd0);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
